sseg_scan_driver: RTL and testbench

Time-multiplexed driver for the board's eight-digit seven-segment display. It sits directly downstream of `reaction_timer`'s digit-formatting logic. It takes eight 5-bit character codes plus a decimal-point mask and scans them onto the shared active-low `sseg`/`an` pins. Inputs are snapshotted once per frame so that counter updates never tear across digits, and a blanking gap is inserted between digits to suppress ghosting.

---
 rtl/sseg_pkg.sv | 33 +++
 rtl/sseg_decode.sv | 40 ++++
 rtl/sseg_scan_driver.sv | 82 ++++++++
 tb/tb_sseg_scan_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display path: character codes and
// active-low glyphs (bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a; dp bit kept off).
package sseg_pkg;

  typedef logic [4:0] char_t;

  localparam char_t CH_H     = 5'h10;
  localparam char_t CH_I     = 5'h11;
  localparam char_t CH_DASH  = 5'h12;
  localparam char_t CH_BLANK = 5'h13;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_I     = 8'hF9;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/sseg_decode.sv
// Combinational character-code to active-low segment decoder with decimal point.
// Codes 0x14..0x1F have no glyph and render blank.
module sseg_decode
  import sseg_pkg::*;
(
  input  char_t      ch_i,
  input  logic       dp_i,
  output logic [7:0] sseg_o
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (ch_i)
      5'h00:    glyph = SEG_0;
      5'h01:    glyph = SEG_1;
      5'h02:    glyph = SEG_2;
      5'h03:    glyph = SEG_3;
      5'h04:    glyph = SEG_4;
      5'h05:    glyph = SEG_5;
      5'h06:    glyph = SEG_6;
      5'h07:    glyph = SEG_7;
      5'h08:    glyph = SEG_8;
      5'h09:    glyph = SEG_9;
      5'h0A:    glyph = SEG_A;
      5'h0B:    glyph = SEG_B;
      5'h0C:    glyph = SEG_C;
      5'h0D:    glyph = SEG_D;
      5'h0E:    glyph = SEG_E;
      5'h0F:    glyph = SEG_F;
      CH_H:     glyph = SEG_H;
      CH_I:     glyph = SEG_I;
      CH_DASH:  glyph = SEG_DASH;
      default:  glyph = SEG_BLANK;
    endcase
    sseg_o = dp_i ? {1'b0, glyph[6:0]} : glyph;
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner: per-frame input snapshot,
// blanking gap at the start of each digit slot, registered active-low outputs.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIV   = 100_000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] chars,
  input  logic [7:0]  dp,
  input  logic        en,
  output logic [7:0]  sseg,
  output logic [7:0]  an
);

  generate
    if (DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
      $error("sseg_scan_driver: need DIV >= 2 and 0 <= BLANK < DIV");
    end
  endgenerate

  localparam int              CW        = $clog2(DIV);
  localparam logic [CW-1:0]   CYC_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   CYC_BLANK = CW'(BLANK);

  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][4:0] snap_chars_q, snap_chars_d;
  logic [7:0]      snap_dp_q, snap_dp_d;
  logic [7:0]      an_q, an_d;
  logic [7:0]      sseg_q, sseg_d;
  logic            frame_start;
  logic            show;
  logic [7:0]      dec_sseg;

  // Capture happens on the edge that starts slot 0; decoding from the _d
  // value lets a BLANK = 0 configuration show the fresh snapshot immediately.
  assign frame_start = (cyc_q == '0) && (idx_q == 3'd0);

  always_comb begin
    cyc_d        = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
    idx_d        = (cyc_q == CYC_LAST) ? idx_q + 3'd1 : idx_q;
    snap_chars_d = frame_start ? chars : snap_chars_q;
    snap_dp_d    = frame_start ? dp : snap_dp_q;
  end

  sseg_decode u_decode (
    .ch_i   (snap_chars_d[idx_q]),
    .dp_i   (snap_dp_d[idx_q]),
    .sseg_o (dec_sseg)
  );

  always_comb begin
    show   = en && (cyc_q >= CYC_BLANK);
    an_d   = show ? ~(8'h01 << idx_q) : 8'hFF;
    sseg_d = show ? dec_sseg : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q        <= '0;
      idx_q        <= 3'd0;
      snap_chars_q <= {8{CH_BLANK}};
      snap_dp_q    <= 8'h00;
      an_q         <= 8'hFF;
      sseg_q       <= 8'hFF;
    end else begin
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      snap_chars_q <= snap_chars_d;
      snap_dp_q    <= snap_dp_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver (DIV = 8, BLANK = 2): frame-position reference
// model feeding an expected queue, directed scenarios, then random traffic.
module tb_sseg_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [39:0] chars = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  sseg;
  logic [7:0]  an;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int          n_edges = 0;
  logic [39:0] frame_chars = '0;
  logic [7:0]  frame_dp = '0;

  sseg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst   (rst),
    .chars (chars),
    .dp    (dp),
    .en    (en),
    .sseg  (sseg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_glyph(input logic [4:0] code, input logic lit);
    logic [7:0] hex_font [16];
    logic [7:0] g;
    hex_font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    if (code < 5'h10)       g = hex_font[code[3:0]];
    else if (code == 5'h10) g = 8'h89;
    else if (code == 5'h11) g = 8'hF9;
    else if (code == 5'h12) g = 8'hBF;
    else                    g = 8'hFF;
    if (lit) g[7] = 1'b0;
    return g;
  endfunction

  // Expected output after this edge, from the frame position since reset.
  task automatic model_push();
    int p, slot, c;
    logic [7:0] e_an, e_seg;
    e_an  = 8'hFF;
    e_seg = 8'hFF;
    if (rst) begin
      n_edges = 0;
    end else begin
      p    = n_edges % FRAME;
      slot = p / DIV;
      c    = p % DIV;
      if (p == 0) begin
        frame_chars = chars;
        frame_dp    = dp;
      end
      if (en && c >= BLANK) begin
        e_an  = ~(8'h01 << slot);
        e_seg = ref_glyph(frame_chars[slot*5 +: 5], frame_dp[slot]);
      end
      n_edges++;
    end
    exp_q.push_back({e_an, e_seg});
  endtask

  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    model_push();
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("an", {8'h00, an}, {8'h00, e[15:8]});
    check_val("sseg", {8'h00, sseg}, {8'h00, e[7:0]});
    check_val("an_onehot_or_off", {15'h0, ($countones(~an) <= 1)}, 16'h1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first_fe;
    int fe_count;

    // Reset held with arbitrary characters.
    rst   = 1'b1;
    chars = {$urandom, $urandom_range(255, 0)};
    dp    = 8'($urandom);
    ticks(5);
    check_val("reset_an", {8'h00, an}, 16'h00FF);
    check_val("reset_sseg", {8'h00, sseg}, 16'h00FF);

    // Release with "HI" on digits 1..0; watch the first digit-0 window.
    rst   = 1'b0;
    chars = {{6{5'h13}}, 5'h10, 5'h11};
    dp    = 8'h00;
    first_fe = 0;
    fe_count = 0;
    for (int k = 1; k <= DIV; k++) begin
      tick();
      if (an == 8'hFE) begin
        fe_count++;
        if (first_fe == 0) first_fe = k;
      end
    end
    check_val("first_an0_edge", 16'(first_fe), 16'(BLANK + 1));
    check_val("an0_length", 16'(fe_count), 16'(DIV - BLANK));
    for (int k = DIV; k < 2 * FRAME; k++) begin
      tick();
      if (an == 8'hFE) check_val("hi_digit0", {8'h00, sseg}, 16'h00F9);
      if (an == 8'hFD) check_val("hi_digit1", {8'h00, sseg}, 16'h0089);
    end

    // Snapshot: switch from all '1' to all '8' + dp[2] during digit-3 slot.
    chars = {8{5'h01}};
    dp    = 8'h00;
    ticks(3 * DIV + 4);
    chars = {8{5'h08}};
    dp    = 8'h04;
    for (int i = 0; i < FRAME - (3 * DIV + 4) + FRAME; i++) begin
      tick();
      if (i < FRAME - (3 * DIV + 4) && an != 8'hFF)
        check_val("snap_hold", {8'h00, sseg}, 16'h00F9);
      if (i >= FRAME - (3 * DIV + 4) && an == 8'hFB)
        check_val("snap_dp2", {8'h00, sseg}, 16'h0000);
    end

    // Enable: drop mid digit-5 window, restore 10 cycles later.
    chars = {$urandom, $urandom_range(255, 0)};
    dp    = 8'($urandom);
    ticks(5 * DIV + 4);
    en = 1'b0;
    tick();
    check_val("en_off", {8'h00, an}, 16'h00FF);
    ticks(9);
    en = 1'b1;
    tick();
    check_val("en_resume", {8'h00, an}, 16'h00BF);
    ticks(FRAME - (5 * DIV + 4) - 11);

    // Reset pulse in digit-4 slot, then unmapped codes 0x14 / 0x1F.
    ticks(4 * DIV + 3);
    rst = 1'b1;
    tick();
    check_val("midframe_rst", {8'h00, an}, 16'h00FF);
    rst   = 1'b0;
    chars = {{6{5'h13}}, 5'h1F, 5'h14};
    dp    = 8'h00;
    for (int i = 0; i < 2 * DIV; i++) begin
      tick();
      if (an == 8'hFE || an == 8'hFD) check_val("unmapped_code", {8'h00, sseg}, 16'h00FF);
      if (i == BLANK) check_val("restart_digit0", {8'h00, an}, 16'h00FE);
    end

    // Random traffic: inputs change at arbitrary points, occasional en/rst.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7, 0) == 0) chars = {$urandom, $urandom_range(255, 0)};
      if ($urandom_range(7, 0) == 0) dp = 8'($urandom);
      en  = ($urandom_range(15, 0) != 0);
      rst = ($urandom_range(149, 0) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
